// File: rtl/auv_pkg.sv
// auv_pkg: shared types, opcode constants and decode helpers for the AUV decode stage.
// Contents: auv_op_e opcode classes, imm_fmt_e immediate formats, auv_state_e
// decode FSM states, auv_dec_t decoded-field record, OPC_* opcodes, INST_NOP.
package auv_pkg;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        OP_LUI    = 4'd1,
        OP_AUIPC  = 4'd2,
        OP_JAL    = 4'd3,
        OP_JALR   = 4'd4,
        OP_BRANCH = 4'd5,
        OP_LOAD   = 4'd6,
        OP_STORE  = 4'd7,
        OP_OPIMM  = 4'd8,
        OP_OP     = 4'd9,
        OP_FENCE  = 4'd10,
        OP_SYSTEM = 4'd11
    } auv_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R} imm_fmt_e;

    typedef enum logic {ST_WARM, ST_RUN} auv_state_e;

    typedef struct packed {
        auv_op_e     op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } auv_dec_t;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0f;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic auv_op_e op_class(input logic [6:0] opc);
        case (opc)
            OPC_LUI:    return OP_LUI;
            OPC_AUIPC:  return OP_AUIPC;
            OPC_JAL:    return OP_JAL;
            OPC_JALR:   return OP_JALR;
            OPC_BRANCH: return OP_BRANCH;
            OPC_LOAD:   return OP_LOAD;
            OPC_STORE:  return OP_STORE;
            OPC_OPIMM:  return OP_OPIMM;
            OPC_OP:     return OP_OP;
            OPC_FENCE:  return OP_FENCE;
            OPC_SYSTEM: return OP_SYSTEM;
            default:    return OP_NONE;
        endcase
    endfunction

    // Unknown opcodes get the R format so they carry a zero immediate.
    function automatic imm_fmt_e imm_fmt(input auv_op_e op);
        return op inside {OP_LUI, OP_AUIPC} ? IMM_U :
               op == OP_JAL                 ? IMM_J :
               op == OP_BRANCH              ? IMM_B :
               op == OP_STORE               ? IMM_S :
               op inside {OP_JALR, OP_LOAD, OP_OPIMM, OP_FENCE, OP_SYSTEM} ? IMM_I : IMM_R;
    endfunction

endpackage

// File: rtl/auv_decode_if.sv
// auv_decode_if: fetch-side and execute-side signals of the decode stage.
// Fetch: if_inst, if_pc, if_pop. Control: jmp. Execute: ex_ready, de_valid and
// the decoded fields de_*. Modport slave is the decode stage, master is its environment.
interface auv_decode_if
    import auv_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
);
    logic [31:0]           if_inst;
    logic [ADDR_WIDTH-3:0] if_pc;
    logic                  if_pop;
    logic                  jmp;
    logic                  ex_ready;
    logic                  de_valid;
    logic [ADDR_WIDTH-3:0] de_pc;
    auv_op_e               de_op;
    logic [2:0]            de_funct3;
    logic                  de_funct7b5;
    logic [4:0]            de_rd;
    logic [4:0]            de_rs1;
    logic [4:0]            de_rs2;
    logic [31:0]           de_imm;
    logic                  de_illegal;

    modport master (
        output if_inst, if_pc, jmp, ex_ready,
        input  if_pop, de_valid, de_pc, de_op, de_funct3, de_funct7b5,
               de_rd, de_rs1, de_rs2, de_imm, de_illegal
    );

    modport slave (
        input  if_inst, if_pc, jmp, ex_ready,
        output if_pop, de_valid, de_pc, de_op, de_funct3, de_funct7b5,
               de_rd, de_rs1, de_rs2, de_imm, de_illegal
    );
endinterface

// File: rtl/auv_immgen.sv
// auv_immgen: combinational RV32I immediate generator, sign-extended from inst[31].
// Ports: inst_i (instruction bits 31:7), fmt_i (immediate format), imm_o (32-bit immediate).
module auv_immgen
    import auv_pkg::*;
(
    input  logic [31:7] inst_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);
    always_comb
        imm_o = fmt_i == IMM_I ? {{20{inst_i[31]}}, inst_i[31:20]} :
                fmt_i == IMM_S ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
                fmt_i == IMM_B ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
                fmt_i == IMM_U ? {inst_i[31:12], 12'h000} :
                fmt_i == IMM_J ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
                32'h0;
endmodule

// File: rtl/auv_decode.sv
// auv_decode: RV32I decode stage holding one decoded instruction toward execute.
// Ports: clk, rst_n (synchronous, active low), bus (auv_decode_if.slave: fetch
// inst/pc/pop, jmp flush, execute ready/valid and decoded de_* fields).
// Option: define AUV_DECODE_ILLEGAL_EN to compute de_illegal; otherwise it is tied 0.
module auv_decode
    import auv_pkg::*;
#(
    parameter int ADDR_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    auv_decode_if.slave bus
);
    auv_state_e            state_q, state_d;
    logic                  valid_q, valid_d, accept, illegal;
    logic [ADDR_WIDTH-3:0] pc_q;
    auv_dec_t              dec_q, dec_d;
    auv_op_e               op;
    imm_fmt_e              fmt;
    logic [31:0]           imm;

    always_ff @(posedge clk)
        if (!rst_n) state_q <= ST_WARM;
        else        state_q <= state_d;

    // The bootrom output is stale for the first cycle after reset, so WARM lasts exactly one cycle.
    always_comb state_d = state_q == ST_WARM ? ST_RUN : state_q;

    always_comb begin
        accept     = rst_n && state_q == ST_RUN && !bus.jmp && (!valid_q || bus.ex_ready);
        bus.if_pop = accept;
    end

    always_comb valid_d = bus.jmp ? 1'b0 : accept ? 1'b1 : valid_q && !bus.ex_ready;

    assign op  = op_class(bus.if_inst[6:0]);
    assign fmt = imm_fmt(op);

    auv_immgen u_immgen (
        .inst_i (bus.if_inst[31:7]),
        .fmt_i  (fmt),
        .imm_o  (imm)
    );

`ifdef AUV_DECODE_ILLEGAL_EN
    logic [6:0] f7;
    logic [2:0] f3;
    assign f7 = bus.if_inst[31:25];
    assign f3 = bus.if_inst[14:12];
    // For OP-IMM only the shifts constrain funct7; other funct3 values use those bits as immediate.
    always_comb
        illegal = bus.if_inst[1:0] != 2'b11 || op == OP_NONE
               || (op == OP_OP && f7 != 7'h00 && f7 != 7'h20)
               || (op == OP_OP && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5)
               || (op == OP_OPIMM && f3 == 3'd1 && f7 != 7'h00)
               || (op == OP_OPIMM && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
               || (op == OP_BRANCH && (f3 == 3'd2 || f3 == 3'd3))
               || (op == OP_LOAD && (f3 == 3'd3 || f3 > 3'd5))
               || (op == OP_STORE && f3 > 3'd2);
`else
    assign illegal = 1'b0;
`endif

    always_comb
        dec_d = '{op: op, funct3: bus.if_inst[14:12], funct7b5: bus.if_inst[30],
                  rd: bus.if_inst[11:7], rs1: bus.if_inst[19:15], rs2: bus.if_inst[24:20],
                  imm: imm, illegal: illegal};

    always_ff @(posedge clk)
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                pc_q  <= bus.if_pc;
                dec_q <= dec_d;
            end
        end

    assign bus.de_valid    = valid_q;
    assign bus.de_pc       = pc_q;
    assign bus.de_op       = dec_q.op;
    assign bus.de_funct3   = dec_q.funct3;
    assign bus.de_funct7b5 = dec_q.funct7b5;
    assign bus.de_rd       = dec_q.rd;
    assign bus.de_rs1      = dec_q.rs1;
    assign bus.de_rs2      = dec_q.rs2;
    assign bus.de_imm      = dec_q.imm;
    assign bus.de_illegal  = dec_q.illegal;
endmodule

// File: tb/tb_auv_decode.sv
// tb_auv_decode: scoreboard bench for auv_decode with a queue-based reference model.
module tb_auv_decode;
    import auv_pkg::*;

    localparam int AW = 24;
`ifdef AUV_DECODE_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    typedef struct packed {
        logic [AW-3:0] pc;
        logic [3:0]    op;
        logic [2:0]    f3;
        logic          f7b5;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [31:0]   imm;
        logic          ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   warm = 1'b1;
    bit   mon_en = 1'b0;

    auv_decode_if #(.ADDR_WIDTH(AW)) bus ();
    auv_decode #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference decode built from the field layouts, using arithmetic shifts for sign extension.
    function automatic exp_t model(input logic [31:0] i, input logic [AW-3:0] pc);
        exp_t e;
        logic signed [31:0] si;
        logic [31:0] sx20, sx25, sx31;
        logic [6:0] f7;
        logic [2:0] f3;
        si = i;
        sx20 = si >>> 20;
        sx25 = si >>> 25;
        sx31 = si >>> 31;
        f7 = i[31:25];
        f3 = i[14:12];
        e.pc = pc; e.f3 = f3; e.f7b5 = i[30];
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.imm = 32'h0;
        case (i[6:0])
            7'h37: begin e.op = OP_LUI;    e.imm = i & 32'hFFFF_F000; end
            7'h17: begin e.op = OP_AUIPC;  e.imm = i & 32'hFFFF_F000; end
            7'h6f: begin e.op = OP_JAL;
                e.imm = (sx31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1); end
            7'h67: begin e.op = OP_JALR;   e.imm = sx20; end
            7'h63: begin e.op = OP_BRANCH;
                e.imm = (sx31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1); end
            7'h03: begin e.op = OP_LOAD;   e.imm = sx20; end
            7'h23: begin e.op = OP_STORE;  e.imm = (sx25 << 5) | 32'(i[11:7]); end
            7'h13: begin e.op = OP_OPIMM;  e.imm = sx20; end
            7'h33: e.op = OP_OP;
            7'h0f: begin e.op = OP_FENCE;  e.imm = sx20; end
            7'h73: begin e.op = OP_SYSTEM; e.imm = sx20; end
            default: e.op = OP_NONE;
        endcase
        e.ill = 1'b0;
`ifdef AUV_DECODE_ILLEGAL_EN
        if (i[1:0] != 2'b11 || e.op == OP_NONE) e.ill = 1'b1;
        if (e.op == OP_OP && !(f7 inside {7'h00, 7'h20})) e.ill = 1'b1;
        if (e.op == OP_OP && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) e.ill = 1'b1;
        if (e.op == OP_OPIMM && f3 == 3'd1 && f7 != 7'h00) e.ill = 1'b1;
        if (e.op == OP_OPIMM && f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) e.ill = 1'b1;
        if (e.op == OP_BRANCH && f3 inside {3'd2, 3'd3}) e.ill = 1'b1;
        if (e.op == OP_LOAD && f3 inside {3'd3, 3'd6, 3'd7}) e.ill = 1'b1;
        if (e.op == OP_STORE && f3 > 3'd2) e.ill = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        logic [31:0] v = $urandom;
        if ($urandom_range(0, 9) != 0) v[6:0] = opcs[$urandom_range(0, 10)];
        if (v[6:0] == 7'h33 && $urandom_range(0, 1) == 1) v[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
        return v;
    endfunction

    // One cycle: drive at negedge, check if_pop, then update the in-flight queue.
    task automatic cyc(input logic [31:0] inst, input logic [AW-3:0] pc, input bit j, input bit rdy);
        bit occ, ep;
        @(negedge clk);
        rst_n = 1'b1;
        occ = q.size() != 0;
        bus.if_inst = j ? INST_NOP : inst;
        bus.if_pc = pc;
        bus.jmp = j;
        bus.ex_ready = rdy;
        ep = !warm && !j && (!occ || rdy);
        #2;
        chk("if_pop", 64'(bus.if_pop), 64'(ep));
        if (j) q.delete();
        if (ep) q.push_back(model(inst, pc));
        warm = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst_n = 1'b0;
            bus.jmp = 1'($urandom_range(0, 1));
            bus.ex_ready = 1'($urandom_range(0, 1));
            bus.if_inst = $urandom;
            #2;
            chk("if_pop_in_reset", 64'(bus.if_pop), 64'(0));
            q.delete();
        end
        warm = 1'b1;
    endtask

    // Monitor: every cycle the presented instruction must match the queue head; pop on handshake.
    initial begin
        exp_t got;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (bus.de_valid !== (q.size() != 0)) begin
                    errors++;
                    $display("FAIL de_valid: got %b expected %b at %0t", bus.de_valid, q.size() != 0, $time);
                end else if (bus.de_valid) begin
                    got = {bus.de_pc, bus.de_op, bus.de_funct3, bus.de_funct7b5, bus.de_rd,
                           bus.de_rs1, bus.de_rs2, bus.de_imm, bus.de_illegal};
                    checks++;
                    if (got !== q[0]) begin
                        errors++;
                        $display("FAIL de_fields: got %h expected %h at %0t", got, q[0], $time);
                    end
                    if (bus.ex_ready && !bus.jmp && rst_n) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.if_inst = INST_NOP;
        bus.if_pc = '0;
        bus.jmp = 1'b0;
        bus.ex_ready = 1'b0;
        do_reset(2);
        chk("rst_de_valid", 64'(bus.de_valid), 64'(0));
        chk("rst_de_op", 64'(bus.de_op), 64'(OP_NONE));
        chk("rst_de_pc", 64'(bus.de_pc), 64'(0));
        chk("rst_de_imm", 64'(bus.de_imm), 64'(0));
        chk("rst_de_misc", 64'({bus.de_rd, bus.de_rs1, bus.de_rs2, bus.de_funct3, bus.de_funct7b5, bus.de_illegal}), 64'(0));
        mon_en = 1'b1;

        cyc(32'h0050_0093, 22'h10, 0, 1);
        chk("warm_pop", 64'(bus.if_pop), 64'(0));
        cyc(32'h0050_0093, 22'h10, 0, 1);
        chk("run_pop", 64'(bus.if_pop), 64'(1));
        for (int k = 0; k < 4; k++) begin
            cyc(rand_inst(), 22'(k), 0, 1);
            if (k == 0) begin
                chk("addi_valid", 64'(bus.de_valid), 64'(1));
                chk("addi_op", 64'(bus.de_op), 64'(OP_OPIMM));
                chk("addi_rd_rs1", 64'({bus.de_rd, bus.de_rs1}), 64'({5'd1, 5'd0}));
                chk("addi_imm", 64'(bus.de_imm), 64'(5));
                chk("addi_pc", 64'(bus.de_pc), 64'(22'h10));
            end else chk("stream_pc", 64'(bus.de_pc), 64'(k - 1));
            chk("stream_pop", 64'(bus.if_pop), 64'(1));
        end
        for (int k = 0; k < 3; k++) begin
            cyc(rand_inst(), 22'd4, 0, 0);
            chk("stall_pc", 64'(bus.de_pc), 64'(3));
        end
        cyc(rand_inst(), 22'd4, 0, 1);
        cyc(rand_inst(), 22'd5, 0, 1);
        chk("release_pc", 64'(bus.de_pc), 64'(4));
        cyc(rand_inst(), 22'd6, 0, 0);
        cyc(rand_inst(), 22'd7, 1, 0);
        chk("jmp_pop", 64'(bus.if_pop), 64'(0));
        cyc(32'hFE00_0EE3, 22'h20, 0, 0);
        chk("flush_valid", 64'(bus.de_valid), 64'(0));
        cyc(32'hFE20_AC23, 22'h21, 0, 1);
        chk("beq_op", 64'(bus.de_op), 64'(OP_BRANCH));
        chk("beq_imm", 64'(bus.de_imm), 64'(32'hFFFF_FFFC));
        cyc(32'hABCD_E1B7, 22'h22, 0, 1);
        chk("sw_imm", 64'(bus.de_imm), 64'(32'hFFFF_FFF8));
        cyc(32'h0010_006F, 22'h23, 0, 1);
        chk("lui_imm", 64'(bus.de_imm), 64'(32'hABCD_E000));
        cyc(32'h0000_0000, 22'h24, 0, 1);
        chk("jal_imm", 64'(bus.de_imm), 64'(32'h0000_0800));
        cyc(32'h4000_1033, 22'h25, 0, 1);
        chk("ill_zero", 64'(bus.de_illegal), 64'(ILL));
        cyc(32'h4000_0033, 22'h26, 0, 1);
        chk("ill_f7_f3", 64'(bus.de_illegal), 64'(ILL));
        cyc(INST_NOP, 22'h27, 0, 1);
        chk("ill_sub", 64'(bus.de_illegal), 64'(0));

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 63) == 0) do_reset($urandom_range(1, 2));
            cyc(rand_inst(), 22'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) cyc(INST_NOP, '0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
